// File: rtl/spi_cmd_slave_if.sv
// SPI pins plus write-frame handshake for spi_cmd_slave.
// The slave modport belongs to the SPI slave; the master modport belongs to the board-control side.
interface spi_cmd_slave_if #(
  parameter int CMD_W   = 41,
  parameter int REPLY_W = 6
);
  logic               spi_clk;
  logic               spi_cs;
  logic               spi_mosi;
  logic               spi_miso;
  logic [REPLY_W-1:0] status;
  logic [CMD_W-1:0]   data;
  logic               dready;
  logic               ack;
  logic               frame_err;

  modport slave (
    input  spi_clk, spi_cs, spi_mosi, status, ack,
    output spi_miso, data, dready, frame_err
  );

  modport master (
    output spi_clk, spi_cs, spi_mosi, status, ack,
    input  spi_miso, data, dready, frame_err
  );
endinterface

// File: rtl/spi_cmd_slave.sv
// SPI command slave: synchronised SCLK/CS/MOSI, write frames on a dready/ack handshake, status read on MISO.
// Optional even-parity trailer bit on write frames when SPI_CMD_PARITY_EN is defined.
module spi_cmd_slave #(
  parameter int            CMD_W       = 41,
  parameter int            OP_W        = 4,
  parameter logic [OP_W-1:0] RD_OPCODE = 4'b1000,
  parameter int            REPLY_W     = 6,
  parameter bit            SAMPLE_RISE = 1'b1,
  parameter int            SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  spi_cmd_slave_if.slave bus
);

`ifdef SPI_CMD_PARITY_EN
  localparam int unsigned FRAME_W = CMD_W + 1;
`else
  localparam int unsigned FRAME_W = CMD_W;
`endif
  localparam int unsigned CNT_W  = $clog2(FRAME_W + 1);
  localparam int unsigned RCNT_W = $clog2(REPLY_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_REPLY, S_DISCARD} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;

  state_t               r_state;
  logic [FRAME_W-1:0]   r_shreg;
  logic [CNT_W-1:0]     r_cnt;
  logic [REPLY_W-1:0]   r_rep;
  logic [RCNT_W-1:0]    r_rcnt;
  logic                 r_miso;
  logic [CMD_W-1:0]     r_data;
  logic                 r_dready;
  logic                 r_frame_err;
  logic                 r_armed;
  logic                 r_overrun;

  logic                 w_sclk, w_cs_s, w_mosi;
  logic                 w_rise, w_fall, w_sample, w_drive, w_cs_rise;
  logic [FRAME_W-1:0]   w_shreg_nx;
  logic [CNT_W-1:0]     w_cnt_nx;

  // CS chain resets to "selected" so a frame in flight at reset is not picked up mid-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise     = w_sclk & ~r_sclk_d;
  assign w_fall     = ~w_sclk & r_sclk_d;
  assign w_sample   = SAMPLE_RISE ? w_rise : w_fall;
  assign w_drive    = SAMPLE_RISE ? w_fall : w_rise;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;
  assign w_shreg_nx = {r_shreg[FRAME_W-2:0], w_mosi};
  assign w_cnt_nx   = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_rep       <= '0;
      r_rcnt      <= '0;
      r_miso      <= 1'b0;
      r_data      <= '0;
      r_dready    <= 1'b0;
      r_frame_err <= 1'b0;
      r_armed     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_cs_s) r_armed <= 1'b1;
      if (r_dready && bus.ack) r_dready <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          r_cnt  <= '0;
          r_rcnt <= '0;
          if (!w_cs_s && r_armed) begin
            if (r_dready) begin
              r_overrun <= 1'b1;
              r_state   <= S_DISCARD;
            end else begin
              r_state   <= S_RECV;
            end
          end
        end

        // A completed frame is committed one clk after its last bit, even if CS rises meanwhile.
        S_RECV: begin
          r_miso <= 1'b0;
          if (r_cnt == CNT_W'(FRAME_W)) begin
`ifdef SPI_CMD_PARITY_EN
            if (^r_shreg) begin
              r_frame_err <= 1'b1;
            end else begin
              r_data   <= r_shreg[FRAME_W-1:1];
              r_dready <= 1'b1;
            end
`else
            r_data   <= r_shreg;
            r_dready <= 1'b1;
`endif
            r_state <= S_DISCARD;
          end else if (w_cs_rise) begin
            if (r_cnt != '0) r_frame_err <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_sample) begin
            r_shreg <= w_shreg_nx;
            r_cnt   <= w_cnt_nx;
            if (w_cnt_nx == CNT_W'(OP_W) && w_shreg_nx[OP_W-1:0] == RD_OPCODE) begin
              r_rep   <= bus.status;
              r_rcnt  <= '0;
              r_state <= S_REPLY;
            end
          end
        end

        S_REPLY: begin
          if (w_cs_rise) begin
            r_miso  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_drive) begin
            if (r_rcnt == RCNT_W'(REPLY_W)) begin
              r_miso  <= 1'b0;
              r_state <= S_DISCARD;
            end else begin
              r_miso <= r_rep[0];
              r_rep  <= r_rep >> 1;
              r_rcnt <= r_rcnt + RCNT_W'(1);
            end
          end
        end

        S_DISCARD: begin
          r_miso <= 1'b0;
          if (w_cs_s) begin
            if (r_overrun) r_frame_err <= 1'b1;
            r_overrun <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.spi_miso  = r_miso;
  assign bus.data      = r_data;
  assign bus.dready    = r_dready;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench for spi_cmd_slave: one rise-sampling and one fall-sampling instance.
// Parity scenario is built when SPI_CMD_PARITY_EN is defined.
module tb_spi_cmd_slave;

`ifdef SPI_CMD_PARITY_EN
  localparam int FLEN = 42;
`else
  localparam int FLEN = 41;
`endif
  localparam int HALF = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   fe_a;
  int   fe_b;

  spi_cmd_slave_if #(.CMD_W(41), .REPLY_W(6)) ifa ();
  spi_cmd_slave_if #(.CMD_W(41), .REPLY_W(6)) ifb ();

  spi_cmd_slave #(
    .CMD_W(41), .OP_W(4), .RD_OPCODE(4'b1000), .REPLY_W(6),
    .SAMPLE_RISE(1'b1), .SYNC_STAGES(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  spi_cmd_slave #(
    .CMD_W(41), .OP_W(4), .RD_OPCODE(4'b1000), .REPLY_W(6),
    .SAMPLE_RISE(1'b0), .SYNC_STAGES(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.frame_err === 1'b1) fe_a++;
    if (ifb.frame_err === 1'b1) fe_b++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk_frame(input logic [40:0] v);
`ifdef SPI_CMD_PARITY_EN
    return {22'b0, v, ^v};
`else
    return {23'b0, v};
`endif
  endfunction

  function automatic logic dready_of(input bit sel);
    return sel ? ifb.dready : ifa.dready;
  endfunction

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_low(input bit sel);
    if (sel) ifb.spi_cs = 1'b0; else ifa.spi_cs = 1'b0;
    half_wait();
  endtask

  task automatic cs_high(input bit sel);
    half_wait();
    if (sel) ifb.spi_cs = 1'b1; else ifa.spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // A: MOSI set while SCLK low, sampled on rise. B: MOSI changes on rise, sampled on fall.
  task automatic spi_bits(input bit sel, input logic [63:0] val, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      if (!sel) begin
        ifa.spi_mosi = val[i];
        half_wait();
        ifa.spi_clk = 1'b1;
        half_wait();
        ifa.spi_clk = 1'b0;
      end else begin
        ifb.spi_clk  = 1'b1;
        ifb.spi_mosi = val[i];
        half_wait();
        ifb.spi_clk = 1'b0;
        half_wait();
      end
    end
  endtask

  // Full frame; lat = clk count from the last sample edge at the pin to dready=1, -1 if never.
  task automatic spi_write(input bit sel, input logic [63:0] fr, input int n, output int lat);
    cs_low(sel);
    spi_bits(sel, fr, n - 1, 1);
    lat = -1;
    if (!sel) begin
      ifa.spi_mosi = fr[0];
      half_wait();
      ifa.spi_clk = 1'b1;
    end else begin
      ifb.spi_clk  = 1'b1;
      ifb.spi_mosi = fr[0];
      half_wait();
      ifb.spi_clk = 1'b0;
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (lat < 0 && dready_of(sel) === 1'b1) lat = k;
    end
    if (!sel) ifa.spi_clk = 1'b0;
    cs_high(sel);
  endtask

  task automatic ack_pulse(input bit sel);
    if (sel) ifb.ack = 1'b1; else ifa.ack = 1'b1;
    @(negedge clk);
    if (sel) ifb.ack = 1'b0; else ifa.ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (ifa.spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", ifa.spi_miso); end
    checks++; if (ifa.data !== 41'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", ifa.data); end
    checks++; if (ifa.dready !== 1'b0) begin errors++; $display("FAIL reset_dready: got %b expected 0", ifa.dready); end
    checks++; if (ifa.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", ifa.frame_err); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write();
    int lat;
    int fe0;
    ack_pulse(0);
    fe0 = fe_a;
    spi_write(0, mk_frame(41'h0_ABCD_1234_5), FLEN, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL write_latency: got %0d expected 4", lat); end
    checks++; if (ifa.data !== 41'h0_ABCD_1234_5) begin errors++; $display("FAIL write_data: got %h expected 0abcd12345", ifa.data); end
    repeat (20) @(negedge clk);
    checks++; if (ifa.dready !== 1'b1) begin errors++; $display("FAIL write_dready_hold: got %b expected 1", ifa.dready); end
    checks++; if (fe_a !== fe0) begin errors++; $display("FAIL write_no_err: got %0d expected %0d", fe_a, fe0); end
    ack_pulse(0);
    checks++; if (ifa.dready !== 1'b0) begin errors++; $display("FAIL write_ack_clear: got %b expected 0", ifa.dready); end
    checks++; if (ifa.data !== 41'h0_ABCD_1234_5) begin errors++; $display("FAIL write_data_after_ack: got %h expected 0abcd12345", ifa.data); end
  endtask

  task automatic test_read();
    logic [3:0] op;
    logic [5:0] st;
    logic       exp;
    int         fe0;
    op  = 4'b1000;
    st  = 6'b101101;
    fe0 = fe_a;
    ifa.status = st;
    cs_low(0);
    for (int k = 1; k <= 10; k++) begin
      ifa.spi_mosi = (k <= 4) ? op[4-k] : 1'b0;
      half_wait();
      ifa.spi_clk = 1'b1;
      half_wait();
      ifa.spi_clk = 1'b0;
      if (k >= 3) begin
        repeat (5) @(negedge clk);
        exp = (k >= 4 && k <= 9) ? st[k-4] : 1'b0;
        checks++;
        if (ifa.spi_miso !== exp) begin
          errors++;
          $display("FAIL read_miso_fall%0d: got %b expected %b", k, ifa.spi_miso, exp);
        end
        repeat (3) @(negedge clk);
      end
    end
    cs_high(0);
    checks++; if (ifa.dready !== 1'b0) begin errors++; $display("FAIL read_dready: got %b expected 0", ifa.dready); end
    checks++; if (fe_a !== fe0) begin errors++; $display("FAIL read_no_err: got %0d expected %0d", fe_a, fe0); end
  endtask

  task automatic test_short_frame();
    int fe0;
    fe0 = fe_a;
    cs_low(0);
    spi_bits(0, 64'h1_2345_6789_A, 40, 21);
    cs_high(0);
    checks++; if (fe_a !== fe0 + 1) begin errors++; $display("FAIL short_frame_err: got %0d expected %0d", fe_a - fe0, 1); end
    checks++; if (ifa.dready !== 1'b0) begin errors++; $display("FAIL short_dready: got %b expected 0", ifa.dready); end
    checks++; if (ifa.data !== 41'h0_ABCD_1234_5) begin errors++; $display("FAIL short_data: got %h expected 0abcd12345", ifa.data); end
  endtask

  task automatic test_overrun();
    int lat;
    int fe0;
    spi_write(0, mk_frame(41'h0_ABCD_1234_5), FLEN, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL overrun_first_latency: got %0d expected 4", lat); end
    fe0 = fe_a;
    spi_write(0, mk_frame(41'h1_0000_0000_1), FLEN, lat);
    checks++; if (fe_a !== fe0 + 1) begin errors++; $display("FAIL overrun_err: got %0d expected %0d", fe_a - fe0, 1); end
    checks++; if (ifa.data !== 41'h0_ABCD_1234_5) begin errors++; $display("FAIL overrun_data: got %h expected 0abcd12345", ifa.data); end
    checks++; if (ifa.dready !== 1'b1) begin errors++; $display("FAIL overrun_dready: got %b expected 1", ifa.dready); end
    ack_pulse(0);
  endtask

  task automatic test_sample_fall();
    int lat;
    int fe0;
    fe0 = fe_b;
    spi_write(1, mk_frame(41'h0_ABCD_1234_5), FLEN, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL fall_latency: got %0d expected 4", lat); end
    checks++; if (ifb.data !== 41'h0_ABCD_1234_5) begin errors++; $display("FAIL fall_data: got %h expected 0abcd12345", ifb.data); end
    checks++; if (fe_b !== fe0) begin errors++; $display("FAIL fall_no_err: got %0d expected %0d", fe_b, fe0); end
    ack_pulse(1);
    checks++; if (ifb.dready !== 1'b0) begin errors++; $display("FAIL fall_ack_clear: got %b expected 0", ifb.dready); end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] fr;
    int          fe0;
    int          lat;
    fr = mk_frame(41'h1_5555_AAAA_F);
    cs_low(0);
    spi_bits(0, fr, FLEN - 1, FLEN - 10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ifa.data !== 41'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", ifa.data); end
    checks++; if (ifa.dready !== 1'b0) begin errors++; $display("FAIL midrst_dready: got %b expected 0", ifa.dready); end
    rst = 1'b0;
    fe0 = fe_a;
    spi_bits(0, fr, FLEN - 11, 0);
    cs_high(0);
    checks++; if (ifa.dready !== 1'b0) begin errors++; $display("FAIL midrst_tail_dready: got %b expected 0", ifa.dready); end
    checks++; if (fe_a !== fe0) begin errors++; $display("FAIL midrst_tail_err: got %0d expected %0d", fe_a, fe0); end
    spi_write(0, mk_frame(41'h0_0000_0000_3), FLEN, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL exact_len_latency: got %0d expected 4", lat); end
    checks++; if (ifa.data !== 41'h0_0000_0000_3) begin errors++; $display("FAIL exact_len_data: got %h expected 3", ifa.data); end
    ack_pulse(0);
  endtask

`ifdef SPI_CMD_PARITY_EN
  task automatic test_parity();
    int lat;
    int fe0;
    fe0 = fe_a;
    spi_write(0, {22'b0, 41'h0_0000_0000_3, 1'b1}, 42, lat);
    checks++; if (lat !== -1) begin errors++; $display("FAIL parity_bad_dready: got lat %0d expected -1", lat); end
    checks++; if (fe_a !== fe0 + 1) begin errors++; $display("FAIL parity_bad_err: got %0d expected %0d", fe_a - fe0, 1); end
    spi_write(0, {22'b0, 41'h0_0000_0000_3, 1'b0}, 42, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL parity_good_latency: got %0d expected 4", lat); end
    checks++; if (ifa.data !== 41'h0_0000_0000_3) begin errors++; $display("FAIL parity_good_data: got %h expected 3", ifa.data); end
    ack_pulse(0);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    fe_a   = 0;
    fe_b   = 0;
    rst    = 1'b1;
    ifa.spi_clk = 1'b0; ifa.spi_cs = 1'b1; ifa.spi_mosi = 1'b0; ifa.ack = 1'b0; ifa.status = 6'b101101;
    ifb.spi_clk = 1'b0; ifb.spi_cs = 1'b1; ifb.spi_mosi = 1'b0; ifb.ack = 1'b0; ifb.status = 6'b000000;

    test_reset();
    test_write();
    test_read();
    test_short_frame();
    test_overrun();
    test_sample_fall();
    test_reset_midframe();
`ifdef SPI_CMD_PARITY_EN
    test_parity();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
